// File: rtl/keyboard_ctrl.sv
// Board input front end: synchronises and debounces buttons/switches, steps the active
// function on change_button, and turns held direction buttons into auto-repeating pulses.
module keyboard_ctrl #(
  parameter int NUM_FUNCS       = 3,
  parameter int IDX_W           = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             East,
  input  logic             West,
  input  logic             North,
  input  logic             South,
  input  logic             SW0,
  input  logic             SW1,
  input  logic             SW2,
  input  logic             SW3,
  input  logic             change_button,
  output logic [IDX_W-1:0] func_index,
  output logic [3:0]       func1_instruction,
  output logic [3:0]       func2_instruction,
  output logic             sys_reset
);

  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX);

  typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_t;

  // Bit map: 0 South, 1 North, 2 West, 3 East, 4..7 SW0..SW3, 8 change_button
  logic [8:0]      raw;
  logic [8:0]      sync1;
  logic [8:0]      sync2;
  logic [8:0]      stable;
  logic [8:0]      stable_d;
  logic [8:0]      rise;
  logic [DB_W-1:0] db_cnt [9];

  logic [3:0]      held;
  logic [3:0]      pulse;
  rpt_state_t      rpt_state [4];
  logic [RPT_W-1:0] rpt_cnt [4];
  logic            change_rise;
  logic            chg_q;

  assign raw         = {change_button, SW3, SW2, SW1, SW0, East, West, North, South};
  assign rise        = stable & ~stable_d;
  assign change_rise = rise[8];

  // A button counts as released in the same cycle its debounced level is about to drop.
  always_comb begin
    held = '0;
    for (int i = 0; i < 4; i++) begin
      held[i] = stable[i] &
                ~((sync2[i] != stable[i]) && (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < 9; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      for (int i = 0; i < 9; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= ~stable[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      func_index <= '0;
      chg_q      <= 1'b0;
      sys_reset  <= 1'b0;
    end else begin
      chg_q     <= change_rise;
      sys_reset <= stable[4];
      if (change_rise) begin
        func_index <= (func_index == IDX_W'(NUM_FUNCS - 1)) ? '0 : func_index + IDX_W'(1);
      end
    end
  end

  // Repeat FSMs; a function change parks every FSM so held buttons need a fresh press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse <= '0;
      for (int i = 0; i < 4; i++) begin
        rpt_state[i] <= RPT_IDLE;
        rpt_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        pulse[i] <= 1'b0;
        if (change_rise || !held[i]) begin
          rpt_state[i] <= RPT_IDLE;
          rpt_cnt[i]   <= '0;
        end else begin
          case (rpt_state[i])
            RPT_IDLE: begin
              if (rise[i]) begin
                pulse[i]     <= 1'b1;
                rpt_state[i] <= RPT_DELAY;
                rpt_cnt[i]   <= '0;
              end
            end
            RPT_DELAY: begin
              if (rpt_cnt[i] == RPT_W'(REPEAT_DELAY - 1)) begin
                pulse[i]     <= 1'b1;
                rpt_state[i] <= RPT_REPEAT;
                rpt_cnt[i]   <= '0;
              end else begin
                rpt_cnt[i] <= rpt_cnt[i] + RPT_W'(1);
              end
            end
            RPT_REPEAT: begin
              if (rpt_cnt[i] == RPT_W'(REPEAT_PERIOD - 1)) begin
                pulse[i]   <= 1'b1;
                rpt_cnt[i] <= '0;
              end else begin
                rpt_cnt[i] <= rpt_cnt[i] + RPT_W'(1);
              end
            end
            default: begin
              rpt_state[i] <= RPT_IDLE;
              rpt_cnt[i]   <= '0;
            end
          endcase
        end
      end
    end
  end

  // chg_q blanks both nibbles for the cycle in which the new func_index first appears.
  assign func1_instruction = (!chg_q && func_index == IDX_W'(0)) ?
                             {stable[7], stable[6], stable[5], pulse[3]} : 4'b0000;
  assign func2_instruction = (!chg_q && func_index == IDX_W'(1)) ? pulse : 4'b0000;

endmodule

// File: tb/tb_keyboard_ctrl.sv
// Directed bench for keyboard_ctrl with short debounce/repeat timings.
module tb_keyboard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       East, West, North, South;
  logic       SW0, SW1, SW2, SW3;
  logic       change_button;
  logic [1:0] func_index;
  logic [3:0] func1_instruction;
  logic [3:0] func2_instruction;
  logic       sys_reset;

  int checks = 0;
  int errors = 0;
  logic [3:0] seen;
  logic [3:0] exp_w;

  keyboard_ctrl #(
    .NUM_FUNCS(3), .IDX_W(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .reset(reset),
    .East(East), .West(West), .North(North), .South(South),
    .SW0(SW0), .SW1(SW1), .SW2(SW2), .SW3(SW3),
    .change_button(change_button),
    .func_index(func_index),
    .func1_instruction(func1_instruction),
    .func2_instruction(func2_instruction),
    .sys_reset(sys_reset)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    {East, West, North, South, SW0, SW1, SW2, SW3, change_button} = '0;
    step(2);
    chk("rst_idx", func_index, 0);
    chk("rst_f1", func1_instruction, 0);
    chk("rst_f2", func2_instruction, 0);
    chk("rst_sys", sys_reset, 0);
    reset = 1'b0;
    step(3);

    // Function stepping: one step per press, wrap after 2, long hold steps once
    change_button = 1'b1;
    step(6);  chk("chg1_early", func_index, 0);
    step(1);  chk("chg1_edge", func_index, 1);
    step(1);  change_button = 1'b0;
    step(10); chk("chg1_hold", func_index, 1);
    change_button = 1'b1; step(8); change_button = 1'b0; step(10);
    chk("chg2", func_index, 2);
    chk("idx2_f1", func1_instruction, 0);
    change_button = 1'b1; step(100);
    chk("chg3_long", func_index, 0);
    change_button = 1'b0; step(10);
    chk("chg3_after", func_index, 0);

    // Function 0: switch levels and East set pulse
    SW3 = 1'b1; SW1 = 1'b1; step(10);
    chk("f1_levels", func1_instruction, 4'b1010);
    East = 1'b1;
    step(6); chk("f1_pre", func1_instruction, 4'b1010);
    step(1); chk("f1_set", func1_instruction, 4'b1011);
    chk("f1_f2_quiet", func2_instruction, 0);
    step(1); chk("f1_post", func1_instruction, 4'b1010);
    East = 1'b0; step(12);
    chk("f1_release", func1_instruction, 4'b1010);

    SW0 = 1'b1;
    step(6); chk("sysrst_pre", sys_reset, 0);
    step(1); chk("sysrst_set", sys_reset, 1);
    SW0 = 1'b0; SW1 = 1'b0; SW3 = 1'b0; step(10);
    chk("sw_clear_f1", func1_instruction, 0);
    chk("sw_clear_sys", sys_reset, 0);

    // East held; change edge coincides with East's repeat pulse slot (N29)
    East = 1'b1;
    step(22);
    change_button = 1'b1;
    step(7);
    chk("chg_cycle_idx", func_index, 1);
    chk("chg_cycle_f1", func1_instruction, 0);
    chk("chg_cycle_f2", func2_instruction, 0);
    seen = '0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      seen = seen | func2_instruction;
    end
    chk("held_east_quiet", seen, 0);
    change_button = 1'b0; East = 1'b0;
    step(12);
    chk("idx_after_chg", func_index, 1);
    East = 1'b1;
    step(6); chk("east_repress_pre", func2_instruction, 0);
    step(1); chk("east_repress", func2_instruction, 4'b1000);
    East = 1'b0; step(12);

    // North glitch of 3 cycles must not propagate
    North = 1'b1; step(3); North = 1'b0;
    seen = '0;
    for (int k = 0; k < 15; k++) begin
      step(1);
      seen = seen | func2_instruction;
    end
    chk("glitch", seen, 0);

    // 20-cycle North press: pulse exactly 7 cycles after raw edge
    North = 1'b1;
    step(6); chk("north_pre", func2_instruction, 0);
    step(1); chk("north_pulse", func2_instruction, 4'b0010);
    step(1); chk("north_post", func2_instruction, 0);
    step(12); North = 1'b0;
    step(15); chk("north_released", func2_instruction, 0);

    // West held 40 cycles: pulses at 7, 17, 20, ..., 44 then nothing after release
    West = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      step(1);
      exp_w = (k == 7 || (k >= 17 && k <= 44 && (k - 17) % 3 == 0)) ? 4'b0100 : 4'b0000;
      chk($sformatf("west_k%0d", k), func2_instruction, exp_w);
      if (k == 40) West = 1'b0;
    end

    // Reset mid-operation with North held in function 1
    North = 1'b1;
    step(12);
    chk("pre_reset_idx", func_index, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_idx", func_index, 0);
    chk("mid_rst_f1", func1_instruction, 0);
    chk("mid_rst_f2", func2_instruction, 0);
    chk("mid_rst_sys", sys_reset, 0);
    step(2);
    reset = 1'b0;
    seen = '0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      seen = seen | func1_instruction | func2_instruction | {3'b000, sys_reset} | {2'b00, func_index};
    end
    chk("post_rst_quiet", seen, 0);
    North = 1'b0;
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
